div_unit: RTL and testbench

Multi-cycle integer divider for the execute stage of the five-stage MIPS core. It implements DIV and DIVU with radix-2 restoring division over 32 iterations. While a division is in flight it raises `div_stall`, which drives the hazard unit's `div_stallE` input and freezes F/D/E/M/W. On completion it presents quotient and remainder for the HI/LO write.

---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the multi-cycle divider.
// master = pipeline side, slave = divider side.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             hold;
    logic             div_stall;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, is_signed, a, b, annul, hold,
        input  div_stall, done, quot, rem
    );

    modport slave (
        input  start, is_signed, a, b, annul, hold,
        output div_stall, done, quot, rem
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// stalls the pipeline while busy and presents sign-corrected HI/LO results.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             done_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes, one iteration step, and sign-corrected results.
    // The full remainder is shifted and one spare bit kept so large unsigned
    // divisors never make a positive trial look negative.
    always_comb begin
        a_neg    = bus.is_signed & bus.a[WIDTH-1];
        b_neg    = bus.is_signed & bus.b[WIDTH-1];
        a_mag    = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag    = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        shifted  = {1'b0, prem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {2'b00, dvs_q};
        qbit     = ~trial[WIDTH+1];
        prem_d   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d    = {dvd_q[WIDTH-2:0], qbit};
        quot_fix = qneg_q ? (~dvd_d + WIDTH'(1)) : dvd_d;
        rem_fix  = rneg_q ? (~prem_d + WIDTH'(1)) : prem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.annul) begin
            // Flush abandons the operation; results keep their last values.
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_q   <= a_mag;
                        dvs_q   <= b_mag;
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        qneg_q  <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_q  <= a_neg;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quot_q  <= quot_fix;
                        rem_q   <= rem_fix;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!bus.hold) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so it bites in the cycle the instruction enters E.
    assign bus.div_stall = ~bus.annul &
                           (((state_q == S_IDLE) & bus.start) | (state_q == S_BUSY));
    assign bus.done      = done_q;
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, stall length, annul, hold and reset.
module tb_div_unit;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.a         = a;
        bus.b         = b;
    endtask

    // Counts stall cycles from the launch cycle until done; bounded.
    task automatic wait_done(output int stalls, output logic ok);
        int cyc;
        stalls = 0;
        ok     = 1'b0;
        #1;
        if (bus.div_stall) stalls++;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk);
            #2;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.div_stall) stalls++;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int   stalls;
        logic ok;
        launch(sgn, a, b);
        wait_done(stalls, ok);
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_stall_len"}, 32'(stalls), 32'd33);
        chk({tag, "_quot"}, bus.quot, eq);
        chk({tag, "_rem"}, bus.rem, er);
        chk({tag, "_stall_in_done"}, 32'(bus.div_stall), 32'd0);
        next_cycle();
        bus.start = 1'b0;
        #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   stalls;
        logic ok;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.annul     = 1'b0;
        bus.hold      = 1'b0;

        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quot", bus.quot, 32'd0);
        chk("rst_rem", bus.rem, 32'd0);
        chk("rst_stall", 32'(bus.div_stall), 32'd0);

        next_cycle();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        next_cycle();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        next_cycle();
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        next_cycle();
        run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        next_cycle();
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        next_cycle();
        run_div("divu_big_dvs", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE);

        // Annul at cycle 10 of a DIVU, then an immediate new divide.
        next_cycle();
        launch(1'b0, 32'd1000, 32'd3);
        for (int i = 1; i < 10; i++) next_cycle();
        bus.annul = 1'b1;
        #1;
        chk("annul_stall_drop", 32'(bus.div_stall), 32'd0);
        next_cycle();
        bus.annul = 1'b0;
        launch(1'b0, 32'd100, 32'd10);
        #1;
        chk("annul_no_done", 32'(bus.done), 32'd0);
        chk("annul_idle_restart", 32'(bus.div_stall), 32'd1);
        #1;
        run_div("after_annul", 1'b0, 32'd100, 32'd10, 32'd10, 32'd0);

        // Hold across DONE with start kept high; hold set during BUSY too.
        next_cycle();
        bus.hold = 1'b1;
        launch(1'b0, 32'd50, 32'd5);
        wait_done(stalls, ok);
        chk("hold_done_seen", 32'(ok), 32'd1);
        chk("hold_stall_len", 32'(stalls), 32'd33);
        chk("hold_quot", bus.quot, 32'd10);
        chk("hold_rem", bus.rem, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) bus.hold = 1'b0;
            #1;
            chk("hold_done_held", 32'(bus.done), 32'd1);
            chk("hold_quot_stable", bus.quot, 32'd10);
            chk("hold_no_stall", 32'(bus.div_stall), 32'd0);
        end
        next_cycle();
        bus.start = 1'b0;
        #1;
        chk("hold_done_end", 32'(bus.done), 32'd0);
        chk("hold_no_restart", 32'(bus.div_stall), 32'd0);

        // Reset at cycle 5 of BUSY drops the operation and clears outputs.
        next_cycle();
        launch(1'b0, 32'd1000, 32'd7);
        for (int i = 1; i < 5; i++) next_cycle();
        next_cycle();
        rst       = 1'b1;
        bus.start = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_quot", bus.quot, 32'd0);
        chk("midrst_rem", bus.rem, 32'd0);
        chk("midrst_idle", 32'(bus.div_stall), 32'd0);
        next_cycle();
        run_div("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
